// File: rtl/ex_stage.sv
// Execute stage: one-cycle ALU ops registered straight to MEM, plus an
// iterative 32-step shift-add multiplier that stalls ID while it runs.
module ex_stage (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        IDValid,
  input  logic        IDRegWrite,
  input  logic        IDMemRead,
  input  logic        IDMemWrite,
  input  logic [4:0]  IDRd,
  input  logic [3:0]  IDALUOp,
  input  logic        IDALUSrc,
  input  logic [31:0] IDRsData,
  input  logic [31:0] IDRtData,
  input  logic [31:0] IDImm,
  output logic        EXStall,
  output logic        EXRegWrite,
  output logic        EXMemRead,
  output logic        EXMemWrite,
  output logic [4:0]  EXRd,
  output logic [31:0] EXData,
  output logic [31:0] EXALUData
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] alu;
  } exo_t;

  localparam logic [3:0] OP_MUL = 4'd12;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [31:0] acc, acc_n, acc_add;
  logic [31:0] mcand, mcand_n;
  logic [31:0] mplier, mplier_n;
  exo_t        cap, cap_n;
  exo_t        out, out_n;

  logic [31:0] opb, alu;

  always_comb begin
    opb = IDALUSrc ? IDImm : IDRtData;
    alu = '0;
    case (IDALUOp)
      4'd0:  alu = IDRsData + opb;
      4'd1:  alu = IDRsData - opb;
      4'd2:  alu = IDRsData & opb;
      4'd3:  alu = IDRsData | opb;
      4'd4:  alu = IDRsData ^ opb;
      4'd5:  alu = ~(IDRsData | opb);
      4'd6:  alu = {31'd0, $signed(IDRsData) < $signed(opb)};
      4'd7:  alu = {31'd0, IDRsData < opb};
      4'd8:  alu = IDRsData << opb[4:0];
      4'd9:  alu = IDRsData >> opb[4:0];
      4'd10: alu = $unsigned($signed(IDRsData) >>> opb[4:0]);
      4'd11: alu = {opb[15:0], 16'd0};
      default: alu = '0;  // MUL goes through the iterative unit; 13-15 yield 0
    endcase
  end

  // Final iteration's add is folded into the output so the result lands on
  // the 32nd BUSY edge rather than one later.
  assign acc_add = mplier[0] ? acc + mcand : acc;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    cap_n    = cap;
    out_n    = '0;
    case (state)
      IDLE: begin
        if (IDValid) begin
          if (IDALUOp == OP_MUL) begin
            mcand_n  = IDRsData;
            mplier_n = opb;
            acc_n    = '0;
            cnt_n    = '0;
            cap_n    = '{IDRegWrite, IDMemRead, IDMemWrite, IDRd, IDRtData, 32'd0};
            state_n  = BUSY;
          end else begin
            out_n = '{IDRegWrite, IDMemRead, IDMemWrite, IDRd, IDRtData, alu};
          end
        end
      end
      BUSY: begin
        acc_n    = acc_add;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + 5'd1;
        if (cnt == 5'd31) begin
          out_n     = cap;
          out_n.alu = acc_add;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cap    <= '0;
      out    <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      cap    <= cap_n;
      out    <= out_n;
    end
  end

  assign EXStall    = (state == BUSY);
  assign EXRegWrite = out.regwrite;
  assign EXMemRead  = out.memread;
  assign EXMemWrite = out.memwrite;
  assign EXRd       = out.rd;
  assign EXData     = out.data;
  assign EXALUData  = out.alu;

endmodule
